mem_responder: RTL
==================

Name: mem_responder

Overview:
- Target-side memory subsystem for the cpu bus.
- Answers instruction fetches, loads and stores issued on mem_re, mem_we, memaddr and memdata.
- Contains a word-addressed RAM, a console transmit FIFO with a valid/ready drain port, and a free-running timer with compare interrupt.
- Sits directly on the cpu bus pins; it is the only responder in the system.

Parameters:
- RAM_ABITS, 12: RAM word-address width; RAM holds 2**RAM_ABITS 32-bit words.
- FIFO_ABITS, 3: console FIFO address width; depth is 2**FIFO_ABITS bytes (max 8 address bits).
- INIT_FILE, "": hex image loaded into RAM at elaboration when non-empty; otherwise RAM contents are undefined.

Ports:
- clk  in  1  system clock, shared with cpu
- rst_n  in  1  asynchronous active-low reset
- mem_re  in  1  read strobe (fetch/load), level-valid for the whole cycle
- mem_we  in  1  write strobe, asserted only during clk-low phase
- memaddr  in  30  word address, changes just after posedge clk
- memdata  inout  32  driven by block only when mem_re && !mem_we, else high-Z
- con_valid  out  1  console FIFO not empty
- con_data  out  8  FIFO head byte; valid when con_valid
- con_ready  in  1  sink accepts head byte at posedge when con_valid
- irq  out  1  sticky timer-compare interrupt

Behaviour:
- Decode:
  - memaddr[29]=0 selects RAM, indexed by memaddr[RAM_ABITS-1:0]. Upper bits are ignored, so addresses alias/wrap.
  - memaddr[29]=1 selects IO, decoded on memaddr[2:0]; IO words 5-7 read 0 and ignore writes.
- Reads:
  - Combinational from memaddr; memdata is stable before negedge clk of the same cycle, giving zero wait states.
  - RAM read returns the stored word. An IO read has no side effects.
- Writes:
  - {mem_we, memaddr, memdata} are captured in a level latch that is transparent while clk is low.
  - The latched values commit at the next posedge clk if the latched mem_we=1.
  - A write never also drives memdata.
- IO map:
  - 0 CON_DATA: write pushes memdata[7:0]; read returns 0.
  - 1 CON_STATUS: read {16'b0, count[7:0], 5'b0, ovf, empty, full}; any write clears ovf.
  - 2 TIMER: read returns the count; write loads it.
  - 3 TIMER_CMP: read/write; reset value 32'hFFFFFFFF.
  - 4 IRQ_ACK: write clears irq; read returns {31'b0, irq}.
- Console FIFO:
  - Circular buffer with read/write pointers and a count of width FIFO_ABITS+1.
  - Pop at posedge when con_valid && con_ready.
  - Push when full: the byte is dropped and ovf is set (sticky).
  - Push and pop in the same cycle while full: both occur, count unchanged, no ovf.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo depth.
  - con_data is the registered head entry and is not X when empty (holds the last value).
- Timer:
  - count increments by 1 every posedge, wrapping from FFFFFFFF to 0.
  - A TIMER write in the same cycle overrides the increment, loading memdata exactly.
  - irq sets at the posedge where the pre-increment count equals TIMER_CMP.
  - irq is cleared by an IRQ_ACK write; when set and ack happen in the same cycle, set wins.
- Reset (rst_n low, asynchronous, any time, including mid-write):
  - FIFO empty, ovf=0, con_valid=0, con_data=0.
  - timer=0, TIMER_CMP=FFFFFFFF, irq=0, write latch cleared.
  - RAM contents are not modified by reset.
  - memdata follows the mem_re && !mem_we rule during reset.
- Release: first active edge is the first posedge clk with rst_n high.

Test Plan:
- RAM: write 32'hDEADBEEF to word 5, then read word 5 and word 5+2**RAM_ABITS -> both return DEADBEEF. memdata is Z during the write cycle.
- FIFO fill, con_ready=0:
  - Push bytes 01..09 with depth 8 -> status count=8, full=1, ovf=1.
  - Raise con_ready -> con_data sequence 01..08, then con_valid=0 and empty=1.
  - Write STATUS -> ovf=0.
- FIFO full, con_ready=1: push 0xAA on the same cycle as a pop -> count stays 8, ovf stays 0, 0xAA emerges last.
- Timer compare:
  - Write TIMER=10, TIMER_CMP=13 -> irq rises 4 cycles after the TIMER write commits.
  - IRQ_ACK write -> irq=0 next cycle.
  - Ack on the exact match cycle -> irq stays 1.
- Reset mid-operation: assert rst_n low asynchronously mid clk-low phase during a CON_DATA write -> no push occurs, and all outputs are at reset values before the next clk edge.
- cpu co-sim: load a program via INIT_FILE (store to CON_DATA in a loop) -> console emits the expected byte string in order.

Source files
------------

// File: rtl/mem_responder_if.sv
// Console drain port of mem_responder.
//
// Handshake: con_valid is high while the console FIFO holds at least one
// byte and con_data is the head byte. A byte is consumed at a rising clk
// edge where con_valid && con_ready. con_ready may be asserted at any time;
// it has no effect while con_valid is low.
//
// Modports:
//   master - the FIFO side (drives con_valid/con_data, samples con_ready)
//   slave  - the console sink (samples con_valid/con_data, drives con_ready)
interface mem_responder_if;
  logic       con_valid;
  logic [7:0] con_data;
  logic       con_ready;

  modport master (output con_valid, output con_data, input con_ready);
  modport slave  (input con_valid, input con_data, output con_ready);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: the only target on the cpu bus. Serves fetches, loads and
// stores with zero wait states from a word-addressed RAM and a small IO page
// (console transmit FIFO, free-running timer with compare interrupt).
//
// Ports:
//   clk, rst_n  system clock (shared with the cpu), async active-low reset
//   mem_re      read strobe, valid for the whole cycle
//   mem_we      write strobe, only asserted during the clk-low phase
//   memaddr     word address; [29]=0 RAM, [29]=1 IO page decoded on [2:0]
//   memdata     bidirectional data; driven here only when mem_re && !mem_we
//   con         console drain port (mem_responder_if.master)
//   irq         sticky timer-compare interrupt
//
// IO page: 0 CON_DATA, 1 CON_STATUS, 2 TIMER, 3 TIMER_CMP, 4 IRQ_ACK,
// 5-7 read as zero and ignore writes.
module mem_responder #(
  parameter int    RAM_ABITS  = 12,
  parameter int    FIFO_ABITS = 3,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [29:0]       memaddr,
  inout  wire  [31:0]       memdata,
  mem_responder_if.master   con,
  output logic              irq
);

  localparam int DEPTH = 1 << FIFO_ABITS;
  localparam logic [FIFO_ABITS-1:0] PTR_ONE  = FIFO_ABITS'(1);
  localparam logic [FIFO_ABITS:0]   CNT_ONE  = (FIFO_ABITS+1)'(1);
  localparam logic [FIFO_ABITS:0]   FULL_CNT = {1'b1, {FIFO_ABITS{1'b0}}};

  // ---------------------------------------------------------------------
  // Write capture. The cpu presents store data during the clk-low phase, so
  // the strobe, address and data are held in a latch that is transparent
  // while clk is low and closes at the rising edge that commits them.
  // ---------------------------------------------------------------------
  logic                 wl_we;
  logic                 wl_io;
  logic [RAM_ABITS-1:0] wl_ram_a;
  logic [2:0]           wl_io_a;
  logic [31:0]          wl_data;

  always_latch begin
    if (!rst_n) begin
      wl_we    <= 1'b0;
      wl_io    <= 1'b0;
      wl_ram_a <= '0;
      wl_io_a  <= '0;
      wl_data  <= '0;
    end else if (!clk) begin
      wl_we    <= mem_we;
      wl_io    <= memaddr[29];
      wl_ram_a <= memaddr[RAM_ABITS-1:0];
      wl_io_a  <= memaddr[2:0];
      wl_data  <= memdata;
    end
  end

  logic wr_ram, wr_con, wr_stat, wr_timer, wr_cmp, wr_ack;
  assign wr_ram   = wl_we && !wl_io;
  assign wr_con   = wl_we && wl_io && (wl_io_a == 3'd0);
  assign wr_stat  = wl_we && wl_io && (wl_io_a == 3'd1);
  assign wr_timer = wl_we && wl_io && (wl_io_a == 3'd2);
  assign wr_cmp   = wl_we && wl_io && (wl_io_a == 3'd3);
  assign wr_ack   = wl_we && wl_io && (wl_io_a == 3'd4);

  // Address bits between the RAM index and the RAM/IO select only alias.
  logic unused_addr;
  assign unused_addr = ^memaddr[28:RAM_ABITS];

  // ---------------------------------------------------------------------
  // RAM (untouched by reset)
  // ---------------------------------------------------------------------
  logic [31:0] ram [1 << RAM_ABITS];

  always_ff @(posedge clk) begin
    if (wr_ram) ram[wl_ram_a] <= wl_data;
  end

  // ---------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------
  logic [7:0]            fifo_mem [DEPTH];
  logic [FIFO_ABITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ABITS:0]   count;
  logic                  ovf;
  logic                  full, empty, do_pop, do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = con.con_valid && con.con_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO lands.
  assign do_push = wr_con && (!full || do_pop);

  assign con.con_valid = !empty;

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= wl_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      con.con_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (wr_con && full && !do_pop) ovf <= 1'b1;
      else if (wr_stat)              ovf <= 1'b0;

      // con_data tracks the entry at the post-edge read pointer. When the
      // popped entry was the last stored one, the incoming push (if any)
      // becomes the head; when the FIFO drains, the last value is held.
      if (do_pop) begin
        if (count > CNT_ONE)  con.con_data <= fifo_mem[rd_ptr + PTR_ONE];
        else if (do_push)     con.con_data <= wl_data[7:0];
      end else if (do_push && empty) begin
        con.con_data <= wl_data[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Timer and compare interrupt
  // ---------------------------------------------------------------------
  logic [31:0] timer, timer_cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      timer_cmp <= 32'hFFFF_FFFF;
      irq       <= 1'b0;
    end else begin
      timer <= wr_timer ? wl_data : timer + 32'd1;
      if (wr_cmp) timer_cmp <= wl_data;
      // Match uses the pre-increment count; a set beats a same-edge ack.
      if (timer == timer_cmp) irq <= 1'b1;
      else if (wr_ack)        irq <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read path: combinational from memaddr, no side effects
  // ---------------------------------------------------------------------
  logic [31:0] rdata;
  logic [7:0]  cnt8;
  assign cnt8 = 8'(count);

  always_comb begin
    rdata = '0;
    if (!memaddr[29]) begin
      rdata = ram[memaddr[RAM_ABITS-1:0]];
    end else begin
      case (memaddr[2:0])
        3'd1:    rdata = {16'b0, cnt8, 5'b0, ovf, empty, full};
        3'd2:    rdata = timer;
        3'd3:    rdata = timer_cmp;
        3'd4:    rdata = {31'b0, irq};
        default: rdata = '0;
      endcase
    end
  end

  assign memdata = (mem_re && !mem_we) ? rdata : 'z;

endmodule
